// File: rtl/reg_wb_queue_pkg.sv
// Shared defaults and helpers for the register write-back queue.
package reg_wb_queue_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 4;

  // Register $zero: writes to it carry no architectural state and are never queued.
  localparam int unsigned REG_ZERO = 32'd0;

  // Distance of a storage slot from the head, i.e. its age rank (0 = oldest).
  function automatic int unsigned slot_age(input int unsigned slot,
                                           input int unsigned head,
                                           input int unsigned depth);
    return (slot + depth - head) % depth;
  endfunction

endpackage

// File: rtl/reg_wb_queue_fwd_search.sv
// Finds the youngest queued write to one decode read address.
module reg_wb_queue_fwd_search
  import reg_wb_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [DEPTH-1:0]             valid,
  input  logic [PTR_W-1:0]             head,
  input  logic [ADDR_W-1:0]            addr,
  output logic                         pend,
  output logic [DATA_W-1:0]            fwd
);

  logic [PTR_W-1:0] slot;

  // Walk from youngest to oldest; the first live match is the value decode must see.
  always_comb begin
    pend = 1'b0;
    fwd  = '0;
    slot = head;
    for (int a = DEPTH - 1; a >= 0; a--) begin
      slot = head + PTR_W'(a);
      if (!pend && valid[slot] && (ent_rd[slot] == addr) &&
          (addr != ADDR_W'(REG_ZERO))) begin
        pend = 1'b1;
        fwd  = ent_data[slot];
      end else begin
        pend = pend;
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// In-order write-back queue feeding the register file write port, with
// pending/forward lookup for the two decode read ports.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_pend,
  output logic [DATA_W-1:0] rs_fwd,
  output logic              rt_pend,
  output logic [DATA_W-1:0] rt_fwd,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] in_data,
  output logic              RegWrite,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0]             valid;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             alu_slot;
  logic [CNT_W-1:0]             count;
  logic ld_live, alu_live, ld_push, alu_push, pop, drop;

  // Producer gating: room for two entries, judged on registered count only.
  always_comb begin
    in_ready = (count <= CNT_W'(DEPTH - 2));
    ld_live  = ld_valid && (ld_rd != ADDR_W'(REG_ZERO));
    alu_live = alu_valid && (alu_rd != ADDR_W'(REG_ZERO));
    ld_push  = ld_live && in_ready;
    alu_push = alu_live && in_ready;
    drop     = (ld_live || alu_live) && !in_ready;
    pop      = (count != '0);
    alu_slot = wr_ptr + PTR_W'(ld_push);
  end

  // Register file write port shows the head entry whenever the queue is non-empty.
  always_comb begin
    RegWrite = pop;
    if (pop) begin
      rd      = ent_rd[rd_ptr];
      in_data = ent_data[rd_ptr];
    end else begin
      rd      = '0;
      in_data = '0;
    end
  end

  // Live-entry mask: slots whose age from the head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CNT_W'(slot_age(i, 32'(rd_ptr), DEPTH)) < count);
    end
  end

  // Pointers, occupancy and sticky overflow; the head drains every cycle it exists.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      wr_ptr   <= wr_ptr + PTR_W'(ld_push) + PTR_W'(alu_push);
      count    <= count + CNT_W'(ld_push) + CNT_W'(alu_push) - CNT_W'(pop);
      overflow <= overflow | drop;
    end
  end

  // Entry storage: the load result takes the older slot when both producers push.
  always_ff @(posedge CLK) begin
    if (ld_push) begin
      ent_rd[wr_ptr]   <= ld_rd;
      ent_data[wr_ptr] <= ld_data;
    end
    if (alu_push) begin
      ent_rd[alu_slot]   <= alu_rd;
      ent_data[alu_slot] <= alu_data;
    end
  end

  reg_wb_queue_fwd_search #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) u_rs_search (
    .ent_rd(ent_rd), .ent_data(ent_data), .valid(valid), .head(rd_ptr),
    .addr(rs), .pend(rs_pend), .fwd(rs_fwd)
  );

  reg_wb_queue_fwd_search #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) u_rt_search (
    .ent_rd(ent_rd), .ent_data(ent_data), .valid(valid), .head(rd_ptr),
    .addr(rt), .pend(rt_pend), .fwd(rt_fwd)
  );

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue with hand-computed expectations.
module tb_reg_wb_queue;

  logic        CLK;
  logic        RST;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        in_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_pend;
  logic [31:0] rs_fwd;
  logic        rt_pend;
  logic [31:0] rt_fwd;
  logic [4:0]  rd;
  logic [31:0] in_data;
  logic        RegWrite;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  reg_wb_queue dut (
    .CLK(CLK), .RST(RST),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .in_ready(in_ready), .rs(rs), .rt(rt),
    .rs_pend(rs_pend), .rs_fwd(rs_fwd), .rt_pend(rt_pend), .rt_fwd(rt_fwd),
    .rd(rd), .in_data(in_data), .RegWrite(RegWrite), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [4:0] lr, input logic [31:0] ldat,
                       input logic av, input logic [4:0] ar, input logic [31:0] adat);
    ld_valid  = lv;
    ld_rd     = lr;
    ld_data   = ldat;
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = adat;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    rs  = 5'd0;
    rt  = 5'd0;
    // 1: reset held two cycles with both producers active
    drive(1'b1, 5'd7, 32'h0000_0007, 1'b1, 5'd8, 32'h0000_0008);
    tick();
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rs = 5'd7;
    #1;
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_in_data", in_data, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rs_pend", 32'(rs_pend), 32'd0);
    check("rst_rs_fwd", rs_fwd, 32'd0);
    RST = 1'b0;

    // 2: single ALU push, visible for one cycle then written
    rs = 5'd5;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t2_rs_pend", 32'(rs_pend), 32'd1);
    check("t2_rs_fwd", rs_fwd, 32'hDEAD_BEEF);
    check("t2_regwrite", 32'(RegWrite), 32'd1);
    check("t2_rd", 32'(rd), 32'd5);
    check("t2_in_data", in_data, 32'hDEAD_BEEF);
    tick();
    check("t2_rs_pend_after", 32'(rs_pend), 32'd0);
    check("t2_rs_fwd_after", rs_fwd, 32'd0);
    check("t2_regwrite_after", 32'(RegWrite), 32'd0);

    // 3: same-cycle ld+alu to one register; youngest forwards, writes in order
    rs = 5'd3;
    rt = 5'd3;
    drive(1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd3, 32'h0000_0022);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t3_rs_fwd", rs_fwd, 32'h0000_0022);
    check("t3_rt_fwd", rt_fwd, 32'h0000_0022);
    check("t3_rt_pend", 32'(rt_pend), 32'd1);
    check("t3_first_rd", 32'(rd), 32'd3);
    check("t3_first_data", in_data, 32'h0000_0011);
    tick();
    check("t3_second_we", 32'(RegWrite), 32'd1);
    check("t3_second_data", in_data, 32'h0000_0022);
    check("t3_second_fwd", rs_fwd, 32'h0000_0022);
    tick();
    check("t3_empty_we", 32'(RegWrite), 32'd0);
    check("t3_empty_pend", 32'(rs_pend), 32'd0);

    // 4: writes to register zero are dropped without overflow
    rs = 5'd0;
    rt = 5'd0;
    drive(1'b1, 5'd0, 32'h0000_00AA, 1'b1, 5'd0, 32'h0000_00BB);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t4_regwrite", 32'(RegWrite), 32'd0);
    check("t4_overflow", 32'(overflow), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_rs_pend", 32'(rs_pend), 32'd0);

    // 5: dual pushes fill to three, forced push overflows, drain stays ordered
    check("t5_ready0", 32'(in_ready), 32'd1);
    drive(1'b1, 5'd10, 32'h0000_00A0, 1'b1, 5'd11, 32'h0000_00A1);
    tick();
    check("t5_ready_cnt2", 32'(in_ready), 32'd1);
    check("t5_head0", 32'(rd), 32'd10);
    drive(1'b1, 5'd12, 32'h0000_00A2, 1'b1, 5'd13, 32'h0000_00A3);
    tick();
    rs = 5'd13;
    rt = 5'd11;
    drive(1'b1, 5'd14, 32'h0000_00A4, 1'b1, 5'd15, 32'h0000_00A5);
    check("t5_ready_cnt3", 32'(in_ready), 32'd0);
    check("t5_head1", 32'(rd), 32'd11);
    check("t5_head1_data", in_data, 32'h0000_00A1);
    check("t5_ovf_before", 32'(overflow), 32'd0);
    check("t5_rs_fwd", rs_fwd, 32'h0000_00A3);
    check("t5_rt_head_fwd", rt_fwd, 32'h0000_00A1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rs = 5'd14;
    #1;
    check("t5_overflow", 32'(overflow), 32'd1);
    check("t5_dropped_pend", 32'(rs_pend), 32'd0);
    check("t5_head2", 32'(rd), 32'd12);
    check("t5_head2_data", in_data, 32'h0000_00A2);
    check("t5_ready_again", 32'(in_ready), 32'd1);
    tick();
    check("t5_head3_data", in_data, 32'h0000_00A3);
    check("t5_head3_rd", 32'(rd), 32'd13);
    tick();
    check("t5_drained", 32'(RegWrite), 32'd0);
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // 6: reset with three entries queued discards them all
    drive(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd7, 32'h0000_0077);
    tick();
    drive(1'b1, 5'd8, 32'h0000_0088, 1'b1, 5'd9, 32'h0000_0099);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rs = 5'd8;
    #1;
    check("t6_pend_before", 32'(rs_pend), 32'd1);
    check("t6_head_before", 32'(rd), 32'd7);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("t6_regwrite", 32'(RegWrite), 32'd0);
    check("t6_rs_pend", 32'(rs_pend), 32'd0);
    check("t6_rd", 32'(rd), 32'd0);
    check("t6_ovf_cleared", 32'(overflow), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_write", 32'(RegWrite), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
